// File: rtl/dl_load_arbiter.sv
// -----------------------------------------------------------------------------
// dl_load_arbiter
//   Multi-core data-load controller between NUM_CORES core load ports and one
//   wide-row data memory. Pending requests are arbitrated round-robin. One
//   memory row is read per access. Each granted core receives its WORD_W word
//   from the returned row, together with a one-cycle done pulse.
//
//   Optional feature macro: DL_ROW_MERGE_EN
//     defined   : every pending core that addresses the leader's row is served
//                 by the same memory access.
//     undefined : only the leader is served per access.
//
// Ports
//   clk        in   1                  clock, rising edge
//   rst        in   1                  synchronous reset, active-high
//   mr         in   NUM_CORES          per-core read request, held until done
//   maddr      in   NUM_CORES*ADDR_W   per-core word address, core i at [i*ADDR_W +: ADDR_W]
//   mem_read   out  1                  data-memory read strobe
//   mem_addr   out  ADDR_W             row address (word address >> SEL_W)
//   mem_rdata  in   ROW_W              row data, valid the cycle after mem_read
//   dout       out  NUM_CORES*WORD_W   per-core returned word, held until next done
//   done       out  NUM_CORES          one-cycle pulse per core, dout slice valid
// -----------------------------------------------------------------------------
module dl_load_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_ROW = 4,
    parameter int ADDR_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            mr,
    input  logic [NUM_CORES*ADDR_W-1:0]     maddr,
    output logic                            mem_read,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [WORD_W*WORDS_PER_ROW-1:0] mem_rdata,
    output logic [NUM_CORES*WORD_W-1:0]     dout,
    output logic [NUM_CORES-1:0]            done
);

    localparam int ROW_W   = WORD_W * WORDS_PER_ROW;
    localparam int SEL_W   = $clog2(WORDS_PER_ROW);
    localparam int RADDR_W = ADDR_W - SEL_W;
    localparam int IDX_W   = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       leader_reg;
    logic [NUM_CORES-1:0]   grant_reg;
    logic [SEL_W-1:0]       sel_reg [NUM_CORES];

    logic [NUM_CORES-1:0]   pend;
    logic [RADDR_W-1:0]     core_row [NUM_CORES];
    logic [SEL_W-1:0]       core_sel [NUM_CORES];
    logic [WORD_W-1:0]      row_words [WORDS_PER_ROW];
    logic [IDX_W-1:0]       leader_next;
    logic [NUM_CORES-1:0]   grant_next;
    logic [IDX_W-1:0]       rr_ptr_next;

    // A core in its done cycle is not pending; if it keeps mr high it is
    // treated as a fresh request on the following cycle.
    assign pend = mr & ~done;

    // Split each core address into row and word-select fields.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign core_row[gi] = maddr[gi*ADDR_W + SEL_W +: RADDR_W];
            assign core_sel[gi] = maddr[gi*ADDR_W +: SEL_W];
        end
    endgenerate

    // Word 0 occupies the most-significant WORD_W bits of the row.
    generate
        for (genvar gi = 0; gi < WORDS_PER_ROW; gi++) begin : g_word
            assign row_words[gi] = mem_rdata[ROW_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    // Round-robin leader: first pending core at or after rr_ptr, wrapping.
    always_comb begin
        int   idx;
        logic found;
        leader_next = rr_ptr_reg;
        found       = 1'b0;
        for (int off = 0; off < NUM_CORES; off++) begin
            idx = int'(rr_ptr_reg) + off;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!found && pend[idx]) begin
                leader_next = IDX_W'(idx);
                found       = 1'b1;
            end
        end
    end

    // Grant mask for the access that starts this cycle.
    always_comb begin
        grant_next = '0;
`ifdef DL_ROW_MERGE_EN
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_next[i] = pend[i] && (core_row[i] == core_row[leader_next]);
        end
`else
        grant_next[leader_next] = 1'b1;
`endif
    end

    assign rr_ptr_next = (leader_reg == IDX_W'(NUM_CORES-1)) ? '0 : leader_reg + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            dout       <= '0;
            done       <= '0;
            rr_ptr_reg <= '0;
            leader_reg <= '0;
            grant_reg  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                sel_reg[i] <= '0;
            end
        end else begin
            done <= '0;
            case (state_reg)
                IDLE: begin
                    if (|pend) begin
                        // Everything needed for the access is latched here so
                        // later changes on mr/maddr cannot disturb it.
                        leader_reg <= leader_next;
                        grant_reg  <= grant_next;
                        for (int i = 0; i < NUM_CORES; i++) begin
                            sel_reg[i] <= core_sel[i];
                        end
                        mem_read   <= 1'b1;
                        mem_addr   <= {{SEL_W{1'b0}}, core_row[leader_next]};
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read  <= 1'b0;
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (grant_reg[i]) begin
                            dout[i*WORD_W +: WORD_W] <= row_words[sel_reg[i]];
                            done[i]                  <= 1'b1;
                        end
                    end
                    rr_ptr_reg <= rr_ptr_next;
                    state_reg  <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
